// File: rtl/fp_pkg.sv
// ----------------------------------------------------------------------------
// fp_pkg
// Shared constants and types for the binary32 multiply path.
//   EXP_BIAS / EXP_MAX : exponent bias and the all-ones (inf/nan) exponent
//   QNAN               : canonical quiet NaN produced for any NaN result
//   *_W                : binary32 field widths and the raw product width
//   s1_t               : normalized beat held between the two pipeline stages
// ----------------------------------------------------------------------------
package fp_pkg;

   localparam int EXP_BIAS = 127;
   localparam int EXP_MAX  = 255;

   localparam logic [31:0] QNAN = 32'h7FC0_0000;

   localparam int SIGN_W = 1;
   localparam int EXP_W  = 8;
   localparam int FRAC_W = 23;
   localparam int PROD_W = 48;

   // Internal exponent is 10-bit two's complement.  This leaves headroom
   // above EXP_MAX for overflow and below zero for underflow detection.
   localparam int EXP_IW = 10;

   typedef struct packed {
      logic                     sign;
      logic signed [EXP_IW-1:0] exp;
      logic [FRAC_W-1:0]        frac;
      logic                     guard;
      logic                     sticky;
      logic                     nan;
      logic                     inf;
      logic                     zero;
   } s1_t;

endpackage

// File: rtl/fp_round_rne.sv
// ----------------------------------------------------------------------------
// fp_round_rne
// Combinational round-to-nearest-even and pack of a normalized significand.
//   frac_i, guard_i, sticky_i : 23-bit fraction plus guard and sticky bits
//   exp_i                     : signed 10-bit biased exponent, pre-rounding
//   sign_i                    : result sign
//   nan_i, inf_i, zero_i      : special-operand classification
//   result_o                  : packed binary32 result
//   ovf_o, unf_o, inexact_o   : exception flags for result_o
// Denormal results are flushed to signed zero.
// ----------------------------------------------------------------------------
module fp_round_rne
   import fp_pkg::*;
(
   input  logic [FRAC_W-1:0] frac_i,
   input  logic              guard_i,
   input  logic              sticky_i,
   input  logic [EXP_IW-1:0] exp_i,
   input  logic              sign_i,
   input  logic              nan_i,
   input  logic              inf_i,
   input  logic              zero_i,
   output logic [31:0]       result_o,
   output logic              ovf_o,
   output logic              unf_o,
   output logic              inexact_o
);

   logic                     round_up;
   logic [FRAC_W:0]          frac_sum;
   logic signed [EXP_IW-1:0] exp_r;
   logic                     inexact_raw;

   // Round up on guard when the discarded part is above half, or exactly
   // half with an odd fraction (ties go to even).
   assign round_up    = guard_i & (sticky_i | frac_i[0]);
   assign frac_sum    = {1'b0, frac_i} + {{FRAC_W{1'b0}}, round_up};
   // A carry out of the fraction means 1.111..1 rounded to 10.000..0; the
   // fraction bits are then already zero, so only the exponent moves.
   assign exp_r       = $signed(exp_i + {{(EXP_IW-1){1'b0}}, frac_sum[FRAC_W]});
   assign inexact_raw = guard_i | sticky_i;

   always_comb begin
      result_o  = '0;
      ovf_o     = 1'b0;
      unf_o     = 1'b0;
      inexact_o = 1'b0;
      if (nan_i) begin
         result_o = QNAN;
      end else if (inf_i) begin
         result_o = {sign_i, 8'hFF, 23'h0};
      end else if (zero_i) begin
         result_o = {sign_i, 31'h0};
      end else if (exp_r >= 10'sd255) begin
         result_o  = {sign_i, 8'hFF, 23'h0};
         ovf_o     = 1'b1;
         inexact_o = 1'b1;
      end else if (exp_r <= 10'sd0) begin
         result_o  = {sign_i, 31'h0};
         unf_o     = 1'b1;
         inexact_o = 1'b1;
      end else begin
         result_o  = {sign_i, exp_r[EXP_W-1:0], frac_sum[FRAC_W-1:0]};
         inexact_o = inexact_raw;
      end
   end

endmodule

// File: rtl/fpmul_norm_round.sv
// ----------------------------------------------------------------------------
// fpmul_norm_round
// Two-stage normalize / round-and-pack stage behind the 24x24 mantissa
// multiplier.  S1 normalizes the 48-bit product, S2 rounds (RNE), flushes
// denormals and packs a binary32 result.
//   clk, rst_n               : clock, asynchronous active-low reset
//   in_valid / in_ready      : input handshake
//   in_sign, in_exp, in_mant : sign, signed exponent ea+eb-127, product in [1,4)
//   in_nan, in_inf, in_zero  : special-operand classification
//   out_valid / out_ready    : output handshake
//   out_result               : packed binary32 result
//   out_ovf, out_unf, out_inexact : exception flags aligned with out_result
//
// Handshake: a beat moves on any cycle where valid and ready are both high.
// Valid never waits on ready; once out_valid is high, out_result and the
// flags stay unchanged until out_ready takes the beat.  in_ready depends
// combinationally on out_ready so a full pipeline keeps streaming.
// ----------------------------------------------------------------------------
module fpmul_norm_round
   import fp_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_sign,
   input  logic [EXP_IW-1:0] in_exp,
   input  logic [PROD_W-1:0] in_mant,
   input  logic              in_nan,
   input  logic              in_inf,
   input  logic              in_zero,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_result,
   output logic              out_ovf,
   output logic              out_unf,
   output logic              out_inexact
);

   logic        s1_valid_q;
   s1_t         s1_q, s1_d;
   logic        s2_valid_q;
   logic [31:0] s2_result_q;
   logic        s2_ovf_q, s2_unf_q, s2_inexact_q;

   logic        s1_load, s2_load;
   logic [31:0] rnd_result;
   logic        rnd_ovf, rnd_unf, rnd_inexact;

   // Each stage refills whenever it is empty or its occupant moves on.
   assign s2_load  = ~s2_valid_q | out_ready;
   assign s1_load  = ~s1_valid_q | s2_load;
   assign in_ready = s1_load;

   // Normalize: the product is either 1x.xxx (bit 47 set) or 01.xxx.
   always_comb begin
      s1_d      = '0;
      s1_d.sign = in_sign;
      s1_d.nan  = in_nan;
      s1_d.inf  = in_inf;
      s1_d.zero = in_zero;
      if (in_mant[47]) begin
         s1_d.frac   = in_mant[46:24];
         s1_d.guard  = in_mant[23];
         s1_d.sticky = |in_mant[22:0];
         s1_d.exp    = $signed(in_exp + 10'd1);
      end else begin
         s1_d.frac   = in_mant[45:23];
         s1_d.guard  = in_mant[22];
         s1_d.sticky = |in_mant[21:0];
         s1_d.exp    = $signed(in_exp);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q <= 1'b0;
         s1_q       <= '0;
      end else if (s1_load) begin
         s1_valid_q <= in_valid;
         if (in_valid) begin
            s1_q <= s1_d;
         end
      end
   end

   fp_round_rne u_round (
      .frac_i    (s1_q.frac),
      .guard_i   (s1_q.guard),
      .sticky_i  (s1_q.sticky),
      .exp_i     (s1_q.exp),
      .sign_i    (s1_q.sign),
      .nan_i     (s1_q.nan),
      .inf_i     (s1_q.inf),
      .zero_i    (s1_q.zero),
      .result_o  (rnd_result),
      .ovf_o     (rnd_ovf),
      .unf_o     (rnd_unf),
      .inexact_o (rnd_inexact)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid_q   <= 1'b0;
         s2_result_q  <= '0;
         s2_ovf_q     <= 1'b0;
         s2_unf_q     <= 1'b0;
         s2_inexact_q <= 1'b0;
      end else if (s2_load) begin
         s2_valid_q <= s1_valid_q;
         if (s1_valid_q) begin
            s2_result_q  <= rnd_result;
            s2_ovf_q     <= rnd_ovf;
            s2_unf_q     <= rnd_unf;
            s2_inexact_q <= rnd_inexact;
         end
      end
   end

   assign out_valid   = s2_valid_q;
   assign out_result  = s2_result_q;
   assign out_ovf     = s2_ovf_q;
   assign out_unf     = s2_unf_q;
   assign out_inexact = s2_inexact_q;

endmodule
